// File: rtl/line_fill_engine.sv
// Cache line fill engine: optional dirty-victim writeback followed by a
// line fetch over a one-cycle-latency synchronous word memory.
module line_fill_engine #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,

    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wb,
    input  logic [ADDR_WIDTH-1:0]          req_fill_addr,
    input  logic [ADDR_WIDTH-1:0]          req_wb_addr,

    output logic [$clog2(BLOCK_WORDS)-1:0] wb_idx,
    input  logic [63:0]                    wb_data,

    output logic                           fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [63:0]                    fill_data,
    output logic                           done,

    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [63:0]                    mem_write_data,
    input  logic [63:0]                    mem_read_data,
    output logic                           mem_read_en,
    output logic                           mem_write_en
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 3;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        LAST
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   wb_base;
    logic [ADDR_WIDTH-1:0]   fill_base;
    logic                    rd_pending;
    logic [IDX_W-1:0]        rd_idx;
    logic [ADDR_WIDTH-1:0]   word_off;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wb_base    <= '0;
            fill_base  <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
        end else begin
            // Read data returns one cycle after issue, so remember which word it is.
            rd_pending <= (state == FILL);
            rd_idx     <= (state == FILL) ? cnt : '0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wb_base   <= req_wb_addr & LINE_MASK;
                        fill_base <= req_fill_addr & LINE_MASK;
                        cnt       <= '0;
                        state     <= req_wb ? WB : FILL;
                    end
                end
                WB: begin
                    if (cnt == '1) begin
                        cnt   <= '0;
                        state <= FILL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FILL: begin
                    if (cnt == '1) begin
                        cnt   <= '0;
                        state <= LAST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        word_off       = ADDR_WIDTH'({cnt, 3'b000});
        req_ready      = (state == IDLE);
        done           = (state == LAST);
        wb_idx         = '0;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;

        case (state)
            WB: begin
                wb_idx         = cnt;
                mem_write_en   = 1'b1;
                mem_addr       = wb_base + word_off;
                mem_write_data = wb_data;
            end
            FILL: begin
                mem_read_en = 1'b1;
                mem_addr    = fill_base + word_off;
            end
            default: begin
            end
        endcase

        fill_we   = rd_pending;
        fill_idx  = rd_idx;
        fill_data = rd_pending ? mem_read_data : '0;
    end

endmodule

// File: tb/tb_line_fill_engine.sv
// Self-checking bench for line_fill_engine: transaction-level timeline model
// compared every cycle, plus directed literal checks.
module tb_line_fill_engine;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wb = 1'b0;
    logic [AW-1:0] req_fill_addr = '0;
    logic [AW-1:0] req_wb_addr = '0;
    logic [IW-1:0] wb_idx;
    logic [63:0]   wb_data;
    logic          fill_we;
    logic [IW-1:0] fill_idx;
    logic [63:0]   fill_data;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_write_data;
    logic [63:0]   mem_read_data = '0;
    logic          mem_read_en;
    logic          mem_write_en;

    logic [63:0]   victim [N];
    logic [63:0]   mem_store [logic [31:0]];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign wb_data = victim[wb_idx];

    line_fill_engine #(
        .BLOCK_WORDS(N),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wb        (req_wb),
        .req_fill_addr (req_fill_addr),
        .req_wb_addr   (req_wb_addr),
        .wb_idx        (wb_idx),
        .wb_data       (wb_data),
        .fill_we       (fill_we),
        .fill_idx      (fill_idx),
        .fill_data     (fill_data),
        .done          (done),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a, ~a};
    endfunction

    // Word memory: one-cycle read latency, writes land at the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_write_en) mem_store[mem_addr] = mem_write_data;
            if (mem_read_en) mem_read_data = mem_word(mem_addr);
        end
    end

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic          ready;
        logic          rd;
        logic          wr;
        logic          we;
        logic          dn;
        logic [31:0]   addr;
        logic [63:0]   wdata;
        logic [IW-1:0] widx;
        logic [IW-1:0] fidx;
        logic [63:0]   fdata;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // A request becomes a per-cycle list: N writes (optional), N reads,
    // and each read's data written into the line one cycle later.
    function automatic void expand(input logic wb, input logic [31:0] wa, input logic [31:0] fa);
        logic [31:0] wbase;
        logic [31:0] fbase;
        exp_t e;
        wbase = wa & ~32'(N * 8 - 1);
        fbase = fa & ~32'(N * 8 - 1);
        if (wb) begin
            for (int k = 0; k < N; k++) begin
                e = '0;
                e.wr = 1'b1;
                e.addr = wbase + 32'(8 * k);
                e.wdata = victim[k];
                e.widx = IW'(k);
                q.push_back(e);
            end
        end
        for (int k = 0; k <= N; k++) begin
            e = '0;
            if (k < N) begin
                e.rd = 1'b1;
                e.addr = fbase + 32'(8 * k);
            end
            if (k > 0) begin
                e.we = 1'b1;
                e.fidx = IW'(k - 1);
                e.fdata = mem_word(fbase + 32'(8 * (k - 1)));
            end
            e.dn = (k == N);
            q.push_back(e);
        end
    endfunction

    initial begin
        cur = idle_exp();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                cur = idle_exp();
            end else begin
                if (cur.ready && req_valid) expand(req_wb, req_wb_addr, req_fill_addr);
                cur = (q.size() != 0) ? q.pop_front() : idle_exp();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_ready", 64'(req_ready), 64'(cur.ready));
            chk("m_rd_en", 64'(mem_read_en), 64'(cur.rd));
            chk("m_wr_en", 64'(mem_write_en), 64'(cur.wr));
            chk("m_addr", 64'(mem_addr), 64'(cur.addr));
            chk("m_wdata", mem_write_data, cur.wdata);
            chk("m_wb_idx", 64'(wb_idx), 64'(cur.widx));
            chk("m_fill_we", 64'(fill_we), 64'(cur.we));
            chk("m_fill_idx", 64'(fill_idx), 64'(cur.fidx));
            chk("m_fill_data", fill_data, cur.fdata);
            chk("m_done", 64'(done), 64'(cur.dn));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic start(input logic wb, input logic [31:0] wa, input logic [31:0] fa);
        req_wb = wb;
        req_wb_addr = wa;
        req_fill_addr = fa;
        req_valid = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic to_next_cycle();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] t1_addr [4];
    logic [63:0] t1_data [4];
    logic [31:0] t2_wa   [4];
    logic [31:0] t2_fa   [4];
    logic [63:0] t2_w    [4];
    logic [31:0] t3_addr [4];
    logic [31:0] t6_addr [4];

    initial begin
        t1_addr = '{32'h100, 32'h108, 32'h110, 32'h118};
        t1_data = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                    64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
        t2_wa   = '{32'h200, 32'h208, 32'h210, 32'h218};
        t2_fa   = '{32'h300, 32'h308, 32'h310, 32'h318};
        t2_w    = '{64'h5700_0000_0000_0000, 64'h5711_1111_1111_1111,
                    64'h5722_2222_2222_2222, 64'h5733_3333_3333_3333};
        t3_addr = '{32'hFFFF_FFE0, 32'hFFFF_FFE8, 32'hFFFF_FFF0, 32'hFFFF_FFF8};
        t6_addr = '{32'h700, 32'h708, 32'h710, 32'h718};
        for (int i = 0; i < 4; i++) begin
            mem_store[t1_addr[i]] = t1_data[i];
            victim[i] = '0;
        end

        // Reset state
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rd_en", 64'(mem_read_en), 64'd0);
        chk("rst_wr_en", 64'(mem_write_en), 64'd0);
        chk("rst_fill_we", 64'(fill_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        #20;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        to_next_cycle();

        // Fill only at 0x100
        start(1'b0, 32'h0, 32'h100);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("t1_rd_addr", 64'(mem_addr), 64'(t1_addr[c-1]));
                chk("t1_rd_en", 64'(mem_read_en), 64'd1);
            end
            if (c >= 2 && c <= 5) begin
                chk("t1_fill_idx", 64'(fill_idx), 64'(c - 2));
                chk("t1_fill_data", fill_data, t1_data[c-2]);
            end
            chk("t1_done", 64'(done), 64'(c == 5));
            chk("t1_ready", 64'(req_ready), 64'(c == 6));
        end
        to_next_cycle();

        // Writeback 0x200 then fill 0x300
        for (int i = 0; i < 4; i++) victim[i] = t2_w[i];
        start(1'b1, 32'h200, 32'h300);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("t2_wr_en", 64'(mem_write_en), 64'd1);
                chk("t2_rd_en", 64'(mem_read_en), 64'd0);
                chk("t2_wr_addr", 64'(mem_addr), 64'(t2_wa[c-1]));
                chk("t2_wr_data", mem_write_data, t2_w[c-1]);
            end else if (c <= 8) begin
                chk("t2_rd_en", 64'(mem_read_en), 64'd1);
                chk("t2_wr_en", 64'(mem_write_en), 64'd0);
                chk("t2_rd_addr", 64'(mem_addr), 64'(t2_fa[c-5]));
            end
            chk("t2_done", 64'(done), 64'(c == 9));
            chk("t2_ready", 64'(req_ready), 64'(c == 10));
        end
        chk("t2_mem_208", mem_word(32'h208), 64'h5711_1111_1111_1111);
        to_next_cycle();

        // Unaligned address at the top of the space
        start(1'b0, 32'h0, 32'hFFFF_FFE7);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) chk("t3_rd_addr", 64'(mem_addr), 64'(t3_addr[c-1]));
            if (c == 5) begin
                chk("t3_done", 64'(done), 64'd1);
                chk("t3_last_data", fill_data, 64'hFFFF_FFF8_0000_0007);
            end
        end
        to_next_cycle();

        // Request held high across completion
        req_wb = 1'b0;
        req_fill_addr = 32'h400;
        req_valid = 1'b1;
        to_next_cycle();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("t4_ready", 64'(req_ready), 64'(c == 6));
            chk("t4_done", 64'(done), 64'(c == 5));
            if (c == 7) begin
                chk("t4_second_rd", 64'(mem_read_en), 64'd1);
                chk("t4_second_addr", 64'(mem_addr), 64'h400);
            end
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;

        // Reset during the third fill cycle
        start(1'b0, 32'h0, 32'h500);
        to_next_cycle();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_rd_en", 64'(mem_read_en), 64'd0);
        chk("t5_fill_we", 64'(fill_we), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_ready", 64'(req_ready), 64'd1);
        chk("t5_addr", 64'(mem_addr), 64'd0);
        #4;
        reset_n = 1'b1;
        to_next_cycle();
        start(1'b0, 32'h0, 32'h600);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("t5_new_addr", 64'(mem_addr), 64'h600);
            chk("t5_new_done", 64'(done), 64'(c == 5));
            if (c == 5) chk("t5_new_data", fill_data, 64'h0000_0618_FFFF_F9E7);
        end
        to_next_cycle();

        // Inputs changed after acceptance
        start(1'b0, 32'h0, 32'h700);
        req_fill_addr = 32'h900;
        req_wb_addr = 32'hA00;
        req_wb = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("t6_rd_addr", 64'(mem_addr), 64'(t6_addr[c-1]));
                chk("t6_wr_en", 64'(mem_write_en), 64'd0);
            end
            chk("t6_done", 64'(done), 64'(c == 5));
        end
        to_next_cycle();

        // Mixed vectors checked by the model alone
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) victim[i] = {$urandom(), $urandom()};
            case (v)
                0: start(1'b1, 32'hFFFF_FFFF, 32'h0000_1234);
                1: start(1'b0, 32'h0, 32'h0000_0FF9);
                default: start(1'b1, 32'h0000_0840, 32'h0000_0860);
            endcase
            repeat (2 * N + 2) @(posedge clk);
            #2;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_fill_engine.md
LINE_FILL_ENGINE -- requirements
Module: line_fill_engine

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4, meaning 64-bit words per cache line; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the following cache-side request ports:
- req_valid, input, 1 bit: line request.
- req_ready, output, 1 bit: engine idle and accepting.
- req_wb, input, 1 bit: dirty-victim writeback precedes the fill.
- req_fill_addr, input, ADDR_WIDTH bits: byte address of the line to fetch.
- req_wb_addr, input, ADDR_WIDTH bits: byte address of the victim line.
REQ-006 SHALL have the following victim-read ports:
- wb_idx, output, log2(BLOCK_WORDS) bits: victim word index.
- wb_data, input, 64 bits: victim word, valid combinationally in the same cycle as wb_idx.
REQ-007 SHALL have the following fill-write ports:
- fill_we, output, 1 bit: fill word strobe.
- fill_idx, output, log2(BLOCK_WORDS) bits: fill word index.
- fill_data, output, 64 bits: fill word.
- done, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have the following memory-side ports, which form the initiator end of the synchronous word memory:
- mem_addr, output, ADDR_WIDTH bits: byte address.
- mem_write_data, output, 64 bits.
- mem_read_data, input, 64 bits.
- mem_read_en, output, 1 bit.
- mem_write_en, output, 1 bit.

Function
REQ-009 SHALL implement states IDLE, WB, FILL, LAST, plus a word counter cnt of log2(BLOCK_WORDS) bits.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-011 SHALL latch req_wb, req_fill_addr and req_wb_addr at acceptance; later changes to these inputs SHALL have no effect on the transfer in progress.
REQ-012 SHALL force both latched addresses to line alignment by clearing the low log2(BLOCK_WORDS*8) bits.
REQ-013 SHALL on acceptance enter WB if req_wb=1, otherwise FILL, with cnt=0.
REQ-014 SHALL in WB, each cycle, drive the following; memory is not stalled:
- wb_idx=cnt, mem_write_en=1, mem_addr=wb_base+8*cnt, mem_write_data=wb_data.
REQ-015 SHALL leave WB for FILL with cnt=0 after the cycle where cnt=BLOCK_WORDS-1.
REQ-016 SHALL in FILL, each cycle, drive mem_read_en=1 and mem_addr=fill_base+8*cnt; it advances to LAST after cnt=BLOCK_WORDS-1.
REQ-017 SHALL treat memory read latency as exactly one cycle: mem_read_data in cycle N+1 answers the read issued in cycle N.
REQ-018 SHALL in the cycle after each read issue drive the following combinationally; fill_we SHALL therefore be high from the second FILL cycle through LAST:
- fill_we=1, fill_idx=index of that read, fill_data=mem_read_data.
REQ-019 SHALL in LAST drive done=1 together with the final fill_we, and return to IDLE on the next edge.
REQ-020 SHALL never assert mem_read_en and mem_write_en in the same cycle.
REQ-021 SHALL compute address increments modulo 2^ADDR_WIDTH; a line at the top of the address space wraps without error.
REQ-022 SHALL drive outputs to zero when not active:
- mem_* outputs zero outside WB/FILL.
- wb_idx zero outside WB.
- fill_* outputs zero when fill_we=0.
REQ-023 SHALL produce total busy time of BLOCK_WORDS+1 cycles for a fill-only request and 2*BLOCK_WORDS+1 cycles for a writeback-plus-fill request.
REQ-024 SHALL ignore req_valid while not in IDLE; a request held across done SHALL be accepted in the first IDLE cycle after completion.

Reset
REQ-025 SHALL on reset_n=0, immediately and regardless of clk:
- enter IDLE with cnt=0.
- clear all latched addresses.
- drive all outputs to 0 except req_ready, which is driven to 1.
REQ-026 SHALL abort an in-progress transfer on reset without asserting done; the partially written cache line is the requester's responsibility.
REQ-027 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Verification
REQ-028 SHALL pass a fill-only test:
- Stimulus: req_fill_addr=0x100, req_wb=0, memory words 0x100..0x118 = A,B,C,D.
- Response: reads at 0x100/108/110/118 in cycles 1-4; fill_we cycles 2-5 with idx 0..3 and data A..D; done in cycle 5; req_ready in cycle 6.
REQ-029 SHALL pass a writeback-plus-fill test:
- Stimulus: req_wb=1, req_wb_addr=0x200, victim words W0..W3, req_fill_addr=0x300.
- Response: writes W0..W3 to 0x200..0x218 in cycles 1-4; reads 0x300..0x318 in cycles 5-8; done in cycle 9.
REQ-030 SHALL pass an unaligned/wrap test:
- Stimulus: req_fill_addr=0xFFFF_FFE7.
- Response: reads at 0xFFFF_FFE0, E8, F0, F8 with no wrap fault.
REQ-031 SHALL pass a busy-request test:
- Stimulus: req_valid held high continuously.
- Response: second accept occurs exactly one cycle after done; req_ready is low throughout the first transfer.
REQ-032 SHALL pass a reset mid-operation test:
- Stimulus: reset_n pulsed low during the third FILL cycle.
- Response: all strobes drop immediately, done is never asserted, req_ready=1, and a new fill afterwards completes normally.
REQ-033 SHALL pass an input-stability test:
- Stimulus: req_fill_addr changed mid-transfer.
- Response: remaining read addresses still follow the latched base.
